// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and constants for the EX-stage hazard detection / forwarding unit.
package hazard_forward_unit_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  // Operand select encodings for the EX operand muxes.
  localparam logic [FWD_W-1:0] FWD_REGFILE = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EXMEM   = 2'b10;
  localparam logic [FWD_W-1:0] FWD_MEMWB   = 2'b01;

  // Architectural zero register; never a forwarding or stall source.
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // Destination tracker entry for the instruction sitting in MEM.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } mem_entry_t;

  // Destination tracker entry for the instruction sitting in WB.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
  } wb_entry_t;

  // True when a tracked producer will write the register a consumer reads.
  function automatic logic fwd_hit(
    input logic             valid,
    input logic             reg_write,
    input logic [REG_W-1:0] rd,
    input logic [REG_W-1:0] src
  );
    return valid & reg_write & (rd != REG_ZERO) & (rd == src);
  endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Forwarding select for one EX operand: MEM producer beats WB producer.
module fwd_select
  import hazard_forward_unit_pkg::*;
(
  input  logic             mem_valid_i,
  input  logic [4:0]       mem_reg_i,
  input  logic             mem_reg_write_i,
  input  logic             wb_valid_i,
  input  logic [4:0]       wb_reg_i,
  input  logic             wb_reg_write_i,
  input  logic [4:0]       src_reg_i,
  output logic [1:0]       sel_o
);

  logic mem_hit_c;
  logic wb_hit_c;

  assign mem_hit_c = fwd_hit(mem_valid_i, mem_reg_write_i, mem_reg_i, src_reg_i);
  assign wb_hit_c  = fwd_hit(wb_valid_i, wb_reg_write_i, wb_reg_i, src_reg_i);

  // Most recent producer wins; fall back to the register file.
  always_comb begin
    sel_o = FWD_REGFILE;
    if (mem_hit_c) begin
      sel_o = FWD_EXMEM;
    end else if (wb_hit_c) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Tracks EX destination registers through MEM/WB, drives operand forwarding
// selects and the one-cycle load-use stall, and counts stall cycles.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 hold,
  input  logic                 ex_valid,
  input  logic [4:0]           ex_write_reg,
  input  logic                 ex_reg_write,
  input  logic                 ex_mem_read,
  input  logic [4:0]           ex_rs,
  input  logic [4:0]           ex_rt,
  input  logic [4:0]           id_rs,
  input  logic [4:0]           id_rt,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  output logic [1:0]           forward_a,
  output logic [1:0]           forward_b,
  output logic                 stall,
  output logic [CNT_WIDTH-1:0] stall_count
);

  mem_entry_t           mem_q, mem_d;
  wb_entry_t            wb_q,  wb_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic load_in_ex_c;
  logic rs_dep_c;
  logic rt_dep_c;
  logic stall_c;

  // Load-use hazard: a real load in EX whose target the ID instruction reads.
  always_comb begin
    load_in_ex_c = ex_valid & ex_mem_read & ex_reg_write & (ex_write_reg != REG_ZERO);
    rs_dep_c     = id_uses_rs & (id_rs == ex_write_reg);
    rt_dep_c     = id_uses_rt & (id_rt == ex_write_reg);
    stall_c      = load_in_ex_c & (rs_dep_c | rt_dep_c) & ~hold & ~Rst;
  end

  // Tracker advance and saturating stall counter; a freeze holds everything.
  always_comb begin
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (!hold) begin
      wb_d.valid       = mem_q.valid;
      wb_d.rd          = mem_q.rd;
      wb_d.reg_write   = mem_q.reg_write;
      mem_d.valid      = ex_valid;
      mem_d.rd         = ex_write_reg;
      mem_d.reg_write  = ex_reg_write;
      mem_d.mem_read   = ex_mem_read;
    end
    if (stall_c && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  fwd_select u_fwd_a (
    .mem_valid_i     (mem_q.valid),
    .mem_reg_i       (mem_q.rd),
    .mem_reg_write_i (mem_q.reg_write),
    .wb_valid_i      (wb_q.valid),
    .wb_reg_i        (wb_q.rd),
    .wb_reg_write_i  (wb_q.reg_write),
    .src_reg_i       (ex_rs),
    .sel_o           (forward_a)
  );

  fwd_select u_fwd_b (
    .mem_valid_i     (mem_q.valid),
    .mem_reg_i       (mem_q.rd),
    .mem_reg_write_i (mem_q.reg_write),
    .wb_valid_i      (wb_q.valid),
    .wb_reg_i        (wb_q.rd),
    .wb_reg_write_i  (wb_q.reg_write),
    .src_reg_i       (ex_rt),
    .sel_o           (forward_b)
  );

  assign stall       = stall_c;
  assign stall_count = cnt_q;

endmodule
